// File: rtl/mul_seq_ctrl.sv
// Sequential repeated-addition multiplier: a four-state controller steps A into P
// while counting B down to zero, using an external zero detector on cnt_out.
module mul_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             eqz_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic [PW-1:0]    product,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TEST = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [PW-1:0]    p_reg, p_next;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        p_next     = p_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    a_next     = a_in;
                    b_next     = b_in;
                    p_next     = '0;
                    state_next = S_TEST;
                end
            end
            // The loop exit comes back from the external detector, not a local compare.
            S_TEST: state_next = eqz_in ? S_DONE : S_ADD;
            S_ADD: begin
                p_next     = p_reg + {{(PW-WIDTH){1'b0}}, a_reg};
                b_next     = b_reg - ONE;
                state_next = S_TEST;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
        end
    end

    assign cnt_out = b_reg;
    assign product = p_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);

    // A wrong detector flag would make the loop run past zero or stop early.
    eqz_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == S_TEST) |-> (eqz_in == (b_reg == '0)));

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: cycle-index reference model plus directed cases.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        eqz_in;
    logic [15:0] cnt_out;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Bench-side zero detector closing the loop.
    assign eqz_in = ~|cnt_out;

    mul_seq_ctrl #(.WIDTH(16), .PW(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .eqz_in  (eqz_in),
        .cnt_out (cnt_out),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation of multiplier b occupies cycles k=1..2b+2 after the
    // accepting edge; (k-1)/2 additions have landed by cycle k.
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [31:0] m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_a = '0; m_b = '0; m_last = '0;
        end else if (m_active) begin
            if (m_k == 2 * int'(m_b) + 2) begin
                m_active = 1'b0;
                m_last   = m_a * m_b;
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_active = 1'b1; m_k = 1; m_a = a_in; m_b = b_in;
        end
    end

    always @(negedge clk) begin
        logic        e_busy, e_done;
        logic [15:0] e_cnt;
        logic [31:0] e_prod;
        if (!rst_n || !m_active) begin
            e_busy = 1'b0; e_done = 1'b0; e_cnt = '0;
            e_prod = rst_n ? m_last : 32'd0;
        end else begin
            e_busy = 1'b1;
            e_done = (m_k == 2 * int'(m_b) + 2);
            e_cnt  = 16'(int'(m_b) - (m_k - 1) / 2);
            e_prod = 32'(longint'(m_a) * longint'((m_k - 1) / 2));
        end
        chk("model_busy", busy, e_busy);
        chk("model_done", done, e_done);
        chk("model_cnt", cnt_out, e_cnt);
        chk("model_product", product, e_prod);
    end

    int cnt_hist[$];

    // Called just after a start-accepting edge; counts cycles until done.
    task automatic wait_done(input int limit, output int lat, output logic [31:0] prod, output int busy_n);
        lat = -1; prod = '0; busy_n = 0;
        cnt_hist.delete();
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            cnt_hist.push_back(int'(cnt_out));
            if (busy) busy_n++;
            if (done) begin
                lat = n; prod = product;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout: got none expected done within %0d cycles", limit);
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [31:0] prod, output int busy_n);
        @(posedge clk); #1;
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2 * int'(b) + 40, lat, prod, busy_n);
    endtask

    initial begin
        int lat, bn;
        logic [31:0] pr;
        logic [15:0] ra, rb;
        int seq[7];
        seq = '{3, 3, 2, 2, 1, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_product", product, 32'd0);
        chk("reset_cnt", cnt_out, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic 7*3
        do_op(16'd7, 16'd3, lat, pr, bn);
        $display("[TB] op a=7 b=3 product=%0d latency=%0d", pr, lat);
        chk("basic_latency", lat, 8);
        chk("basic_product", pr, 32'd21);
        chk("basic_busy_cycles", bn, 8);
        for (int i = 0; i < 7; i++)
            chk("basic_cnt_seq", (i < cnt_hist.size()) ? cnt_hist[i] : -1, seq[i]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("basic_idle_busy", busy, 1'b0);
        chk("basic_hold_product", product, 32'd21);

        // Zero multiplier
        do_op(16'hFFFF, 16'd0, lat, pr, bn);
        $display("[TB] op a=ffff b=0 product=%0h latency=%0d", pr, lat);
        chk("zero_latency", lat, 2);
        chk("zero_product", pr, 32'd0);
        chk("zero_busy_cycles", bn, 2);

        // Wide products
        do_op(16'hFFFF, 16'h0003, lat, pr, bn);
        $display("[TB] op a=ffff b=3 product=%0h latency=%0d", pr, lat);
        chk("max3_product", pr, 32'h0002_FFFD);
        do_op(16'hFFFF, 16'h1000, lat, pr, bn);
        $display("[TB] op a=ffff b=1000 product=%0h latency=%0d", pr, lat);
        chk("big_product", pr, 32'h0FFF_F000);
        chk("big_latency", lat, 8194);

        // Zero multiplicand still iterates
        do_op(16'd0, 16'd5, lat, pr, bn);
        $display("[TB] op a=0 b=5 product=%0h latency=%0d", pr, lat);
        chk("a0_product", pr, 32'd0);
        chk("a0_latency", lat, 12);

        // Start while busy, then start held across done
        @(posedge clk); #1;
        a_in = 16'd4; b_in = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_in = 16'd9; b_in = 16'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(40, lat, pr, bn);
        $display("[TB] op a=4 b=5 (busy start ignored) product=%0d", pr);
        chk("busy_start_product", pr, 32'd20);
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("gap_idle_busy", busy, 1'b0);
        chk("gap_idle_product", product, 32'd20);
        @(posedge clk); #1 start = 1'b0;
        wait_done(60, lat, pr, bn);
        $display("[TB] op a=9 b=9 (held start) product=%0d latency=%0d", pr, lat);
        chk("held_start_product", pr, 32'd81);
        chk("held_start_latency", lat, 20);

        // Reset mid-run
        @(posedge clk); #1;
        a_in = 16'd5; b_in = 16'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-run busy=%0b product=%0h cnt=%0h", busy, product, cnt_out);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_product", product, 32'd0);
        chk("midrst_cnt", cnt_out, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_done", done, 1'b0);
            chk("postrst_busy", busy, 1'b0);
        end

        // Random pairs
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 64));
            do_op(ra, rb, lat, pr, bn);
            $display("[TB] rand a=%0h b=%0d product=%0h latency=%0d", ra, rb, pr, lat);
            chk("rand_product", pr, ra * rb);
            chk("rand_latency", lat, 2 * int'(rb) + 2);
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
